ika9958_rcc: RTL

Reset and clock control for the IKA9958 VDP core, directly upstream of screen timing. Divides the master crystal-rate clock into dot-clock and CPU-clock enables, tracks the 4-cycle dot phase, and produces a synchronized, stretched internal reset. Screen timing, VRAM sequencing and the CPU interface consume its enables; no other block divides the master clock.

---
 rtl/ika9958_pkg.sv | 21 ++
 rtl/ika9958_rstsync.sv | 45 ++++
 rtl/ika9958_rcc.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ika9958_pkg.sv
// ika9958_pkg
// Shared types and constants for the IKA9958 reset/clock control block.
//   dot_phase_t    : 2-bit dot phase counter value (0..3)
//   cpu_cnt_t      : 3-bit master/6 CPU clock counter value (0..5)
//   DOT_DIV        : master cycles per dot in normal (256-dot) mode
//   DOT_DIV_HIRES  : master cycles per dot in 512-dot mode
//   CPU_DIV        : master cycles per CPU clock period
//   PH_RISE/PH_FALL: normal-mode phases whose strobes raise/lower the dot clock
package ika9958_pkg;

    typedef logic [1:0] dot_phase_t;
    typedef logic [2:0] cpu_cnt_t;

    localparam int DOT_DIV       = 4;
    localparam int DOT_DIV_HIRES = 2;
    localparam int CPU_DIV       = 6;

    localparam dot_phase_t PH_RISE = 2'd3;
    localparam dot_phase_t PH_FALL = 2'd1;

endpackage

// File: rtl/ika9958_rstsync.sv
// ika9958_rstsync
// Reset synchronizer and release stretcher. The asynchronous reset clears
// everything immediately; release passes through a 2-FF synchronizer and is
// then held off for RST_STRETCH further enabled cycles.
// Ports:
//   i_clk    : master clock
//   i_rst_n  : asynchronous active-low reset input
//   i_cen    : active-high master-cycle enable
//   o_rst_n  : stretched internal reset, active-low, synchronous release
module ika9958_rstsync #(
    parameter int RST_STRETCH = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_cen,
    output logic o_rst_n
);

    localparam int             CW      = $clog2(RST_STRETCH + 1);
    localparam logic [CW-1:0]  CNT_END = CW'(RST_STRETCH);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_rst_n <= 1'b0;
        end else if (i_cen) begin
            r_sync <= {r_sync[0], 1'b1};
            // Count only once the synchronized release is seen; saturate at
            // the end value so the released state is stable.
            if (r_sync[1] && (r_cnt != CNT_END)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Release one cycle after the counter has reached its end value.
            r_rst_n <= (r_cnt == CNT_END);
        end
    end

    assign o_rst_n = r_rst_n;

endmodule

// File: rtl/ika9958_rcc.sv
// ika9958_rcc
// Reset and clock control for the IKA9958 VDP core. Produces dot-clock and
// CPU-clock enables from the master clock, tracks the 4-cycle dot phase and
// generates the stretched internal reset.
// Ports:
//   i_EMUCLK      : master clock
//   i_RST_n       : asynchronous active-low reset
//   i_CEN_n       : active-low master-cycle enable (high freezes all state)
//   i_HIRES       : 512-dot mode request, sampled at the end of each dot
//   o_RST_n       : internal reset, active-low
//   o_PHASE       : dot phase 0..3
//   o_DCLK        : registered dot clock level
//   o_DCLK_PCEN   : dot clock rises after this cycle
//   o_DCLK_NCEN   : dot clock falls after this cycle
//   o_CPUCLK      : registered master/6 clock level
//   o_CPUCLK_PCEN : CPU clock rises after this cycle
module ika9958_rcc
    import ika9958_pkg::*;
#(
    parameter int RST_STRETCH = 16
) (
    input  logic       i_EMUCLK,
    input  logic       i_RST_n,
    input  logic       i_CEN_n,
    input  logic       i_HIRES,
    output logic       o_RST_n,
    output logic [1:0] o_PHASE,
    output logic       o_DCLK,
    output logic       o_DCLK_PCEN,
    output logic       o_DCLK_NCEN,
    output logic       o_CPUCLK,
    output logic       o_CPUCLK_PCEN
);

    localparam dot_phase_t PH_LAST  = dot_phase_t'(DOT_DIV - 1);
    localparam dot_phase_t HR_MASK  = dot_phase_t'(DOT_DIV_HIRES - 1);
    localparam cpu_cnt_t   CPU_LAST = cpu_cnt_t'(CPU_DIV - 1);
    localparam cpu_cnt_t   CPU_FALL = cpu_cnt_t'(CPU_DIV / 2 - 1);

    logic       w_rst_n;
    logic       w_en;
    logic       w_run;
    logic       w_dclk_rise;
    logic       w_dclk_fall;
    logic       w_cpu_rise;
    logic       w_cpu_fall;

    dot_phase_t r_phase;
    cpu_cnt_t   r_cpu_cnt;
    logic       r_hires_q;
    logic       r_dclk;
    logic       r_cpuclk;

    ika9958_rstsync #(
        .RST_STRETCH (RST_STRETCH)
    ) u_rstsync (
        .i_clk   (i_EMUCLK),
        .i_rst_n (i_RST_n),
        .i_cen   (w_en),
        .o_rst_n (w_rst_n)
    );

    assign w_en  = ~i_CEN_n;
    assign w_run = w_en & w_rst_n;

    // Phase decode. In hires mode the dot period is two master cycles, so
    // only the low phase bit matters.
    always_comb begin
        w_dclk_rise = 1'b0;
        w_dclk_fall = 1'b0;
        if (r_hires_q) begin
            w_dclk_rise = ((r_phase & HR_MASK) == HR_MASK);
            w_dclk_fall = ((r_phase & HR_MASK) == '0);
        end else begin
            w_dclk_rise = (r_phase == PH_RISE);
            w_dclk_fall = (r_phase == PH_FALL);
        end
    end

    assign w_cpu_rise = (r_cpu_cnt == CPU_LAST);
    assign w_cpu_fall = (r_cpu_cnt == CPU_FALL);

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_phase   <= '0;
            r_cpu_cnt <= '0;
            r_hires_q <= 1'b0;
            r_dclk    <= 1'b0;
            r_cpuclk  <= 1'b0;
        end else if (!w_rst_n) begin
            // Held during the release stretch so the first released cycle
            // starts cleanly at phase 0 / count 0.
            r_phase   <= '0;
            r_cpu_cnt <= '0;
            r_hires_q <= 1'b0;
            r_dclk    <= 1'b0;
            r_cpuclk  <= 1'b0;
        end else if (w_en) begin
            r_phase   <= (r_phase == PH_LAST) ? dot_phase_t'(0) : r_phase + 2'd1;
            r_cpu_cnt <= (r_cpu_cnt == CPU_LAST) ? cpu_cnt_t'(0) : r_cpu_cnt + 3'd1;

            // Mode only changes on a dot boundary so no dot is cut short.
            if (r_phase == PH_LAST) begin
                r_hires_q <= i_HIRES;
            end

            // Levels follow the strobes, so they start low after reset and
            // pick up their steady-state shape at the first rising strobe.
            if (w_dclk_rise) begin
                r_dclk <= 1'b1;
            end else if (w_dclk_fall) begin
                r_dclk <= 1'b0;
            end

            if (w_cpu_rise) begin
                r_cpuclk <= 1'b1;
            end else if (w_cpu_fall) begin
                r_cpuclk <= 1'b0;
            end
        end
    end

    assign o_RST_n       = w_rst_n;
    assign o_PHASE       = r_phase;
    assign o_DCLK        = r_dclk;
    assign o_CPUCLK      = r_cpuclk;
    assign o_DCLK_PCEN   = w_run & w_dclk_rise;
    assign o_DCLK_NCEN   = w_run & w_dclk_fall;
    assign o_CPUCLK_PCEN = w_run & w_cpu_rise;

endmodule
